framebuffer_arbiter: RTL and testbench

Arbitrates the single-port framebuffer RAM between the VGA read path and the camera-capture write path. The VGA controller's pixel fetches cannot stall, so they always win. Writes are buffered in a small FIFO and drained into RAM on any cycle without a read, typically during blanking. The block sits between `vga_controller` and the framebuffer RAM, in the `vga_clk_25` domain.

---
 rtl/framebuffer_arbiter.sv | 90 +++++++++
 tb/tb_framebuffer_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_arbiter.sv
// rtl/framebuffer_arbiter.sv - single-port framebuffer RAM arbiter, VGA reads over buffered capture writes
// Reads always win the RAM port; capture writes queue in a FIFO and drain on read-free cycles.
module framebuffer_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          vga_clk_25,
  input  logic                          reset_n,
  input  logic                          rd_en,
  input  logic [ADDR_WIDTH-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rd_valid,
  input  logic                          wr_valid,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          wr_ready,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  output logic                          mem_we,
  input  logic [DATA_WIDTH-1:0]         mem_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, READ, WRITE} grant_t;

  grant_t                grant;
  logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [PW:0]           wr_ptr;
  logic [PW:0]           rd_ptr;
  logic                  empty;
  logic                  full;
  logic                  push;
  logic                  rd_pipe;

  // Extra pointer MSB separates a full ring from an empty one.
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign wr_ready   = reset_n && !full;
  assign push       = wr_valid && wr_ready;
  assign fifo_level = wr_ptr - rd_ptr;

  always_ff @(posedge vga_clk_25) begin
    if (push) begin
      fifo_addr[wr_ptr[PW-1:0]] <= wr_addr;
      fifo_data[wr_ptr[PW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge vga_clk_25) begin
    if (!reset_n) begin
      grant     <= IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_pipe   <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;

      // Head pop uses the registered pointers, so a same-cycle push is never bypassed.
      if (rd_en) begin
        grant    <= READ;
        mem_we   <= 1'b0;
        mem_addr <= rd_addr;
      end else if (!empty) begin
        grant     <= WRITE;
        mem_we    <= 1'b1;
        mem_addr  <= fifo_addr[rd_ptr[PW-1:0]];
        mem_wdata <= fifo_data[rd_ptr[PW-1:0]];
        rd_ptr    <= rd_ptr + 1'b1;
      end else begin
        grant  <= IDLE;
        mem_we <= 1'b0;
      end

      // RAM returns data the cycle after the READ grant; capture it one cycle later.
      rd_pipe  <= (grant == READ);
      rd_valid <= rd_pipe;
      if (rd_pipe) rd_data <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// tb/tb_framebuffer_arbiter.sv - directed self-checking bench for framebuffer_arbiter
module tb_framebuffer_arbiter;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          wr_valid = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic [4:0]    fifo_level;

  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  framebuffer_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .vga_clk_25(clk), .reset_n(reset_n),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .fifo_level(fifo_level)
  );

  // Synchronous-read RAM model with a side port for preloading.
  logic [DW-1:0] ram [0:65535];
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_en) ram[pre_addr] <= pre_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  logic [AW+DW-1:0] wlog [$];
  always @(negedge clk) if (mem_we === 1'b1) wlog.push_back({mem_addr, mem_wdata});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_en = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'($urandom); rd_addr = 16'($urandom);
      wr_valid = 1'($urandom); wr_addr = 16'($urandom); wr_data = 8'($urandom);
      tick();
    end
    total++;
    if (wr_ready !== 1'b0) $display("FAIL reset_wr_ready: got %b want 0", wr_ready);
    else passed++;
    total++;
    if ({mem_we, mem_addr, mem_wdata, rd_data, rd_valid, fifo_level} !== '0)
      $display("FAIL reset_outputs: we=%b addr=%h wdata=%h rd_data=%h rd_valid=%b level=%0d want all 0",
               mem_we, mem_addr, mem_wdata, rd_data, rd_valid, fifo_level);
    else passed++;
    rd_en = 1'b0; wr_valid = 1'b0; reset_n = 1'b1;
    #1;
    total++;
    if (wr_ready !== 1'b1 || fifo_level !== 5'd0)
      $display("FAIL reset_release: wr_ready=%b level=%0d want 1/0", wr_ready, fifo_level);
    else passed++;
  endtask

  task automatic test_read_latency();
    preload(16'h1234, 8'hA5);
    rd_en = 1'b1; rd_addr = 16'h1234;
    tick();
    rd_en = 1'b0;
    total++;
    if (mem_addr !== 16'h1234 || mem_we !== 1'b0 || rd_valid !== 1'b0)
      $display("FAIL read_n1: addr=%h we=%b rd_valid=%b want 1234/0/0", mem_addr, mem_we, rd_valid);
    else passed++;
    tick();
    total++;
    if (rd_valid !== 1'b0) $display("FAIL read_n2_valid: got %b want 0", rd_valid);
    else passed++;
    tick();
    total++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hA5)
      $display("FAIL read_n3: rd_valid=%b rd_data=%h want 1/a5", rd_valid, rd_data);
    else passed++;
    tick();
    total++;
    if (rd_valid !== 1'b0 || rd_data !== 8'hA5)
      $display("FAIL read_hold: rd_valid=%b rd_data=%h want 0/a5", rd_valid, rd_data);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp [4];
    exp[0] = 8'h5A; exp[1] = 8'hC3; exp[2] = 8'h0F; exp[3] = 8'h96;
    for (int k = 0; k < 4; k++) preload(16'(16'h2000 + k), exp[k]);
    for (int i = 0; i < 8; i++) begin
      if (i >= 3 && i <= 6) begin
        total++;
        if (rd_valid !== 1'b1 || rd_data !== exp[i-3])
          $display("FAIL b2b_read_%0d: rd_valid=%b rd_data=%h want 1/%h", i - 3, rd_valid, rd_data, exp[i-3]);
        else passed++;
      end else if (i == 7) begin
        total++;
        if (rd_valid !== 1'b0) $display("FAIL b2b_end_valid: got %b want 0", rd_valid);
        else passed++;
      end
      rd_en = (i < 4);
      rd_addr = 16'(16'h2000 + i);
      tick();
    end
    rd_en = 1'b0;
  endtask

  task automatic test_idle_write();
    wr_valid = 1'b1; wr_addr = 16'h0010; wr_data = 8'h3C;
    tick();
    wr_valid = 1'b0;
    total++;
    if (fifo_level !== 5'd1 || mem_we !== 1'b0)
      $display("FAIL idle_write_n1: level=%0d we=%b want 1/0", fifo_level, mem_we);
    else passed++;
    tick();
    total++;
    if (mem_we !== 1'b1 || mem_addr !== 16'h0010 || mem_wdata !== 8'h3C || fifo_level !== 5'd0)
      $display("FAIL idle_write_n2: we=%b addr=%h wdata=%h level=%0d want 1/0010/3c/0",
               mem_we, mem_addr, mem_wdata, fifo_level);
    else passed++;
    tick();
    total++;
    if (mem_we !== 1'b0) $display("FAIL idle_write_n3: we=%b want 0", mem_we);
    else passed++;
  endtask

  task automatic test_read_priority();
    int acc = 0;
    int saw_we = 0;
    for (int c = 0; c < 40; c++) begin
      rd_en = 1'b1; rd_addr = 16'(16'h3000 + c);
      wr_valid = (acc < 20);
      wr_addr = 16'(16'h0100 + acc); wr_data = 8'(8'h40 + acc);
      #1;
      if (mem_we !== 1'b0) saw_we++;
      if (wr_valid && wr_ready) acc++;
      tick();
    end
    total++;
    if (saw_we != 0 || mem_we !== 1'b0) $display("FAIL prio_no_write: write cycles=%0d want 0", saw_we);
    else passed++;
    total++;
    if (acc != 16 || fifo_level !== 5'd16 || wr_ready !== 1'b0)
      $display("FAIL prio_full: accepted=%0d level=%0d wr_ready=%b want 16/16/0", acc, fifo_level, wr_ready);
    else passed++;
    rd_en = 1'b0; wr_valid = 1'b0;
    tick();
    for (int k = 0; k < 16; k++) begin
      total++;
      if (mem_we !== 1'b1 || mem_addr !== 16'(16'h0100 + k) || mem_wdata !== 8'(8'h40 + k))
        $display("FAIL prio_drain_%0d: we=%b addr=%h wdata=%h want 1/%h/%h",
                 k, mem_we, mem_addr, mem_wdata, 16'(16'h0100 + k), 8'(8'h40 + k));
      else passed++;
      tick();
    end
    total++;
    if (mem_we !== 1'b0 || fifo_level !== 5'd0)
      $display("FAIL prio_drained: we=%b level=%0d want 0/0", mem_we, fifo_level);
    else passed++;
  endtask

  task automatic test_simul_push_pop();
    int bad = 0;
    wlog.delete();
    for (int k = 0; k < 15; k++) begin
      rd_en = (k < 5); rd_addr = '0;
      wr_valid = 1'b1; wr_addr = 16'(16'h0200 + k); wr_data = 8'(8'h80 + k);
      if (k >= 5 && (fifo_level !== 5'd5 || wr_ready !== 1'b1)) bad++;
      tick();
    end
    wr_valid = 1'b0; rd_en = 1'b0;
    total++;
    if (bad != 0 || fifo_level !== 5'd5)
      $display("FAIL pushpop_level: bad cycles=%0d level=%0d want 0/5", bad, fifo_level);
    else passed++;
    for (int i = 0; i < 10; i++) tick();
    total++;
    if (wlog.size() != 15 || fifo_level !== 5'd0)
      $display("FAIL pushpop_count: writes=%0d level=%0d want 15/0", wlog.size(), fifo_level);
    else passed++;
    bad = 0;
    for (int k = 0; k < 15 && k < wlog.size(); k++)
      if (wlog[k] !== {16'(16'h0200 + k), 8'(8'h80 + k)}) bad++;
    total++;
    if (bad != 0) $display("FAIL pushpop_order: out-of-order writes=%0d want 0", bad);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    wlog.delete();
    for (int k = 0; k < 8; k++) begin
      rd_en = 1'b1; rd_addr = 16'h1234;
      wr_valid = 1'b1; wr_addr = 16'(16'h0300 + k); wr_data = 8'(k);
      tick();
    end
    total++;
    if (fifo_level !== 5'd8) $display("FAIL midreset_fill: level=%0d want 8", fifo_level);
    else passed++;
    reset_n = 1'b0; rd_en = 1'b0; wr_valid = 1'b0;
    tick();
    total++;
    if (wr_ready !== 1'b0 || fifo_level !== 5'd0 || mem_we !== 1'b0 || rd_valid !== 1'b0 || mem_addr !== 16'h0)
      $display("FAIL midreset_state: ready=%b level=%0d we=%b rd_valid=%b addr=%h want 0/0/0/0/0",
               wr_ready, fifo_level, mem_we, rd_valid, mem_addr);
    else passed++;
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (mem_we !== 1'b0 || rd_valid !== 1'b0) bad++;
      tick();
    end
    total++;
    if (bad != 0 || wlog.size() != 0 || fifo_level !== 5'd0)
      $display("FAIL midreset_quiet: active cycles=%0d writes=%0d level=%0d want 0/0/0",
               bad, wlog.size(), fifo_level);
    else passed++;
    rd_en = 1'b1; rd_addr = 16'h1234;
    tick();
    rd_en = 1'b0;
    tick();
    tick();
    total++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hA5)
      $display("FAIL midreset_recover: rd_valid=%b rd_data=%h want 1/a5", rd_valid, rd_data);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_back_to_back();
    test_idle_write();
    test_read_priority();
    test_simul_push_pop();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
